// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets inside
// the 8-word window, field widths and the priority-resolution helper.
package intc_pkg;

    localparam int INTC_MAX_SRC  = 24;
    localparam int INTC_WORD_W   = 12;
    localparam int INTC_ADDR_W   = 24;
    localparam int INTC_ID_W     = 5;

    // Word offsets inside the register window
    localparam logic [2:0] INTC_PEND_L = 3'd0;
    localparam logic [2:0] INTC_PEND_H = 3'd1;
    localparam logic [2:0] INTC_EN_L   = 3'd2;
    localparam logic [2:0] INTC_EN_H   = 3'd3;
    localparam logic [2:0] INTC_VBASE  = 3'd4;
    localparam logic [2:0] INTC_CUR    = 3'd5;
    localparam logic [2:0] INTC_FORCE  = 3'd6;

    // Bit of the irq word that is always set while an interrupt is active,
    // so the handler address can never be zero.
    localparam int INTC_IRQ_VALID_BIT = 11;

    // Currently selected interrupt: valid flag plus source index
    typedef struct packed {
        logic                 valid;
        logic [INTC_ID_W-1:0] id;
    } intc_cur_t;

    // Lowest set index wins; scanning downward lets the last hit be the lowest.
    function automatic intc_cur_t intc_prio(input logic [INTC_MAX_SRC-1:0] act);
        intc_cur_t r;
        r.valid = |act;
        r.id    = '0;
        for (int i = INTC_MAX_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                r.id = INTC_ID_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Processor data-bus connection of the interrupt controller. The processor
// side is the master; the controller is a slave peripheral.
interface interrupt_controller_if;
    import intc_pkg::*;

    logic [INTC_ADDR_W-1:0] address;
    logic                   mem_write;
    logic [INTC_WORD_W-1:0] data_in;
    logic [INTC_WORD_W-1:0] data_out;
    logic                   sel;

    modport master (
        output address,
        output mem_write,
        output data_in,
        input  data_out,
        input  sel
    );

    modport slave (
        input  address,
        input  mem_write,
        input  data_in,
        output data_out,
        output sel
    );

endinterface

// File: rtl/irq_sync_edge.sv
// Per-line two-flop synchroniser followed by a previous-value flop; emits a
// single-cycle pulse for every rising edge seen on the synchronised line.
module irq_sync_edge #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src,
    output logic [WIDTH-1:0] rise
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_line
            logic sync1_reg;
            logic sync2_reg;
            logic prev_reg;

            // Synchronise the asynchronous line and remember its last value
            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    prev_reg  <= 1'b0;
                end else begin
                    sync1_reg <= src[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                end
            end

            // A held-high line yields exactly one pulse
            assign rise[gi] = sync2_reg & ~prev_reg;
        end
    endgenerate

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: latches source edges as pending,
// masks them with an enable register, resolves the highest-priority active
// source and drives a registered 24-bit handler address on irq.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = 24'o77770000,
    parameter int          NUM_SRC   = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     src,
    interrupt_controller_if.slave  bus,
    output logic [23:0]            irq
);

    // Implemented source bits; everything above reads 0 and ignores writes
    localparam logic [INTC_MAX_SRC-1:0] SRC_MASK =
        (NUM_SRC >= INTC_MAX_SRC) ? {INTC_MAX_SRC{1'b1}}
                                  : INTC_MAX_SRC'((25'd1 << NUM_SRC) - 25'd1);
    localparam logic [INTC_ID_W-1:0] NUM_SRC_ID = INTC_ID_W'(NUM_SRC);

    logic [INTC_MAX_SRC-1:0] pend_reg,  pend_next;
    logic [INTC_MAX_SRC-1:0] en_reg,    en_next;
    logic [INTC_WORD_W-1:0]  vbase_reg, vbase_next;
    logic [INTC_WORD_W-1:0]  data_out_reg, data_out_next;
    logic                    sel_reg;
    logic [23:0]             irq_reg,   irq_next;

    logic [NUM_SRC-1:0]      rise;
    logic [INTC_MAX_SRC-1:0] rise_full;
    logic [INTC_MAX_SRC-1:0] set_vec;
    logic [INTC_MAX_SRC-1:0] clr_vec;
    logic [INTC_MAX_SRC-1:0] active;
    intc_cur_t               cur;

    logic                    hit;
    logic [2:0]              offset;
    logic                    wr;
    logic [INTC_ID_W-1:0]    force_id;

    irq_sync_edge #(
        .WIDTH (NUM_SRC)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .src  (src),
        .rise (rise)
    );

    // Widen the edge pulses to the full 24-bit register layout
    genvar gi;
    generate
        for (gi = 0; gi < INTC_MAX_SRC; gi++) begin : g_rise
            if (gi < NUM_SRC) begin : g_impl
                assign rise_full[gi] = rise[gi];
            end else begin : g_none
                assign rise_full[gi] = 1'b0;
            end
        end
    endgenerate

    assign hit      = (bus.address[23:3] == BASE_ADDR[23:3]);
    assign offset   = bus.address[2:0];
    assign wr       = bus.mem_write & hit;
    assign force_id = bus.data_in[INTC_ID_W-1:0];

    assign active   = pend_reg & en_reg;
    assign cur      = intc_prio(active);

    // Collect set requests (edges, FORCE) and clear requests (PEND write, ack)
    always_comb begin
        set_vec = rise_full;
        clr_vec = '0;
        if (wr) begin
            case (offset)
                INTC_PEND_L: clr_vec[11:0]  = bus.data_in;
                INTC_PEND_H: clr_vec[23:12] = bus.data_in;
                INTC_CUR: begin
                    if (cur.valid) begin
                        clr_vec[cur.id] = 1'b1;
                    end
                end
                INTC_FORCE: begin
                    if (force_id < NUM_SRC_ID) begin
                        set_vec[force_id] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next register-file state; set is applied after clear so it always wins
    always_comb begin
        pend_next  = ((pend_reg & ~clr_vec) | set_vec) & SRC_MASK;
        en_next    = en_reg;
        vbase_next = vbase_reg;
        if (wr) begin
            case (offset)
                INTC_EN_L:  en_next[11:0]  = bus.data_in;
                INTC_EN_H:  en_next[23:12] = bus.data_in;
                INTC_VBASE: vbase_next     = bus.data_in;
                default: ;
            endcase
        end
        en_next = en_next & SRC_MASK;
    end

    // Handler address from the current state: {VBASE, 1, 000000, id}
    always_comb begin
        irq_next = '0;
        if (cur.valid) begin
            irq_next                     = {vbase_reg, 12'd0};
            irq_next[INTC_IRQ_VALID_BIT] = 1'b1;
            irq_next[INTC_ID_W-1:0]      = cur.id;
        end
    end

    // Read mux, captured at the edge like a synchronous RAM
    always_comb begin
        data_out_next = '0;
        if (hit) begin
            case (offset)
                INTC_PEND_L: data_out_next = pend_reg[11:0];
                INTC_PEND_H: data_out_next = pend_reg[23:12];
                INTC_EN_L:   data_out_next = en_reg[11:0];
                INTC_EN_H:   data_out_next = en_reg[23:12];
                INTC_VBASE:  data_out_next = vbase_reg;
                INTC_CUR:    data_out_next = {cur.valid, 6'd0, cur.id};
                default:     data_out_next = '0;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_reg     <= '0;
            en_reg       <= '0;
            vbase_reg    <= '0;
            data_out_reg <= '0;
            sel_reg      <= 1'b0;
            irq_reg      <= '0;
        end else begin
            pend_reg     <= pend_next;
            en_reg       <= en_next;
            vbase_reg    <= vbase_next;
            data_out_reg <= data_out_next;
            sel_reg      <= hit;
            irq_reg      <= irq_next;
        end
    end

    assign bus.data_out = data_out_reg;
    assign bus.sel      = sel_reg;
    assign irq          = irq_reg;

endmodule
